// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round scheduler.
package whack_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GAP    = 3'd1,
        SHOW   = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int         DEF_GAP_CYCLES  = 200000;
    localparam int         DEF_SHOW_CYCLES = 500000;
    localparam int         DEF_ROUNDS      = 16;
    localparam logic [7:0] LFSR_MASK       = 8'hB8;

    // Galois step: shift right, fold the mask in when a one falls out.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
    endfunction

    function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
        idx_to_onehot = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Galois LFSR; exposes its low OUT_W bits.
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [7:0] SEED  = 8'hA5,
    parameter int         OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [OUT_W-1:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // next-state of the shift register
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // state register, seeded on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mole_round_sched.sv
// Whack-a-mole round scheduler: gap/show timing, mole pick, one verdict per round.
module mole_round_sched
    import whack_pkg::*;
#(
    parameter int         GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int         SHOW_CYCLES = DEF_SHOW_CYCLES,
    parameter int         ROUNDS      = DEF_ROUNDS,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] btn,
    output logic [7:0] mole_onehot,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [4:0] round_cnt,
    output logic       busy,
    output logic       done
);

    localparam int MAX_CYC = (GAP_CYCLES > SHOW_CYCLES) ? GAP_CYCLES : SHOW_CYCLES;
    localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [4:0]    LAST_RND  = 5'(ROUNDS);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    round_q, round_d;
    logic [7:0]    mole_q, mole_d;
    logic [2:0]    prev_q, prev_d;
    logic [7:0]    btn_q;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    lfsr_idx_s;
    logic [2:0]    pick_s;
    logic [7:0]    rise_s;

    mole_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (3)
    ) u_lfsr (
        .clk_i  (clk),
        .rst_i  (rst),
        .lfsr_o (lfsr_idx_s)
    );

    // next-state, timer, verdict and registered-output decode
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        round_d = round_q;
        mole_d  = mole_q;
        prev_d  = prev_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        rise_s  = btn & ~btn_q;
        // Never repeat the previous mole; 3-bit add wraps 7 -> 0.
        pick_s  = (lfsr_idx_s == prev_q) ? (lfsr_idx_s + 3'd1) : lfsr_idx_s;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                    round_d = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (timer_q == TW'(0)) begin
                    state_d = SHOW;
                    timer_d = SHOW_LOAD;
                    prev_d  = pick_s;
                    mole_d  = idx_to_onehot(pick_s);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            SHOW: begin
                if ((rise_s & mole_q) != 8'd0) begin
                    hit_d   = 1'b1;
                    state_d = RESULT;
                    mole_d  = 8'd0;
                    round_d = round_q + 5'd1;
                end else if ((rise_s != 8'd0) || (timer_q == TW'(0))) begin
                    miss_d  = 1'b1;
                    state_d = RESULT;
                    mole_d  = 8'd0;
                    round_d = round_q + 5'd1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            RESULT: begin
                if (round_q == LAST_RND) begin
                    state_d = DONE;
                end else begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                    round_d = 5'd0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                mole_d  = 8'd0;
            end
        endcase

        busy_d = (state_d == GAP) || (state_d == SHOW) || (state_d == RESULT);
        done_d = (state_d == DONE);
    end

    // state, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= TW'(0);
            round_q <= 5'd0;
            mole_q  <= 8'd0;
            prev_q  <= 3'd0;
            btn_q   <= 8'd0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            round_q <= round_d;
            mole_q  <= mole_d;
            prev_q  <= prev_d;
            btn_q   <= btn;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mole_onehot = mole_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign round_cnt   = round_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mole_round_sched.sv
// Scoreboard bench for mole_round_sched (GAP=4, SHOW=8, ROUNDS=3).
module tb_mole_round_sched;

    localparam int GAP_C  = 4;
    localparam int SHOW_C = 8;
    localparam int RNDS   = 3;
    localparam int SEQ_N  = 51;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] btn;
    logic [7:0] mole_onehot;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [4:0] round_cnt;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic       hit;
        logic [4:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] seq_rec [2][SEQ_N];
    logic [7:0] m;
    logic [7:0] prev;
    logic [7:0] wrong;

    always #5 clk = ~clk;

    mole_round_sched #(
        .GAP_CYCLES  (GAP_C),
        .SHOW_CYCLES (SHOW_C),
        .ROUNDS      (RNDS),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .btn         (btn),
        .mole_onehot (mole_onehot),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .round_cnt   (round_cnt),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input logic hit, input logic [4:0] cnt);
        exp_t e;
        e.hit = hit;
        e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic wait_show(output logic [7:0] mo);
        mo = 8'd0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mole_onehot != 8'd0) begin
                mo = mole_onehot;
                break;
            end
        end
        if (mo == 8'd0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_show: no mole lit within 40 cycles");
        end
    endtask

    // Verdict monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (hit_pulse || miss_pulse) begin
            chk("pulse_exclusive", 32'(hit_pulse & miss_pulse), 32'd0);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got hit=%0b miss=%0b, expected none", hit_pulse, miss_pulse);
            end else begin
                e = sb_q.pop_front();
                chk("verdict_kind", 32'(hit_pulse), 32'(e.hit));
                chk("verdict_round_cnt", 32'(round_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic run_seq(input int which);
        logic [7:0] mo;
        logic [7:0] pv;
        int         k;
        pv = 8'h01;
        k  = 0;
        for (int g = 0; g < SEQ_N / RNDS; g++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int r = 0; r < RNDS; r++) begin
                wait_show(mo);
                chk("seq_onehot", 32'($countones(mo)), 32'd1);
                chk("seq_differs", 32'(mo != pv), 32'd1);
                pv = mo;
                seq_rec[which][k] = mo;
                k++;
                btn = mo;
                expect_v(1'b1, 5'(r + 1));
                tick();
                btn = 8'd0;
                tick();
            end
            chk("seq_done", 32'(done), 32'd1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        btn   = 8'd0;
        prev  = 8'h01;
        tick();
        tick();
        chk("rst_mole", 32'(mole_onehot), 32'd0);
        chk("rst_hit", 32'(hit_pulse), 32'd0);
        chk("rst_miss", 32'(miss_pulse), 32'd0);
        chk("rst_round", 32'(round_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // game 1, round 1: hit on second SHOW cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("gap_dark_c0", 32'(mole_onehot), 32'd0);
        for (int i = 1; i < GAP_C; i++) begin
            tick();
            chk("gap_dark", 32'(mole_onehot), 32'd0);
        end
        tick();
        m = mole_onehot;
        chk("show_onehot_at_gap", 32'($countones(m)), 32'd1);
        chk("first_not_prev0", 32'(m != prev), 32'd1);
        prev = m;
        tick();
        btn = m;
        expect_v(1'b1, 5'd1);
        tick();
        chk("hit_next_cycle", 32'(hit_pulse), 32'd1);
        chk("result_mole_clear", 32'(mole_onehot), 32'd0);
        chk("round_cnt_1", 32'(round_cnt), 32'd1);
        btn = 8'd0;
        tick();
        chk("hit_one_cycle", 32'(hit_pulse), 32'd0);
        chk("busy_in_gap", 32'(busy), 32'd1);

        // round 2: timeout after the 8th SHOW cycle
        wait_show(m);
        chk("mole_differs_r2", 32'(m != prev), 32'd1);
        prev = m;
        expect_v(1'b0, 5'd2);
        for (int i = 1; i < SHOW_C; i++) begin
            tick();
            chk("show_hold", 32'(mole_onehot), 32'(m));
            chk("no_early_miss", 32'(miss_pulse), 32'd0);
        end
        tick();
        chk("timeout_miss", 32'(miss_pulse), 32'd1);
        tick();

        // round 3: wrong button, immediate miss, game ends
        wait_show(m);
        chk("mole_differs_r3", 32'(m != prev), 32'd1);
        prev = m;
        wrong = (m == 8'h08) ? 8'h01 : {m[6:0], m[7]};
        btn = wrong;
        expect_v(1'b0, 5'd3);
        tick();
        chk("wrong_miss", 32'(miss_pulse), 32'd1);
        chk("wrong_no_hit", 32'(hit_pulse), 32'd0);
        btn = 8'd0;
        tick();
        chk("done_set", 32'(done), 32'd1);
        chk("done_not_busy", 32'(busy), 32'd0);
        chk("done_round_cnt", 32'(round_cnt), 32'd3);
        tick();
        chk("done_held", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_round0", 32'(round_cnt), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_done_clr", 32'(done), 32'd0);

        // game 2, round 1: buttons held from GAP never count; start ignored
        btn = 8'hFF;
        wait_show(m);
        chk("mole_differs_g2r1", 32'(m != prev), 32'd1);
        prev = m;
        expect_v(1'b0, 5'd1);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_mole", 32'(mole_onehot), 32'(m));
        chk("start_ignored_cnt", 32'(round_cnt), 32'd0);
        for (int i = 4; i < SHOW_C; i++) begin
            tick();
            chk("held_no_verdict", 32'(miss_pulse | hit_pulse), 32'd0);
        end
        tick();
        chk("held_timeout_miss", 32'(miss_pulse), 32'd1);
        btn = 8'd0;
        tick();

        // round 2: correct plus wrong button together is a hit
        wait_show(m);
        chk("mole_differs_g2r2", 32'(m != prev), 32'd1);
        prev = m;
        btn = m | 8'h80;
        expect_v(1'b1, 5'd2);
        tick();
        chk("combo_hit", 32'(hit_pulse), 32'd1);
        chk("combo_no_miss", 32'(miss_pulse), 32'd0);
        btn = 8'd0;
        tick();

        wait_show(m);
        chk("mole_differs_g2r3", 32'(m != prev), 32'd1);
        btn = m;
        expect_v(1'b1, 5'd3);
        tick();
        btn = 8'd0;
        tick();
        chk("g2_done", 32'(done), 32'd1);

        // reset-seeded sequence, then reset mid-SHOW and replay
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        run_seq(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_show(m);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_mole", 32'(mole_onehot), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_round", 32'(round_cnt), 32'd0);
        chk("midrst_pulses", 32'(hit_pulse | miss_pulse), 32'd0);
        tick();
        rst = 1'b0;
        run_seq(1);
        for (int i = 0; i < SEQ_N; i++) begin
            chk("seq_repro", 32'(seq_rec[1][i]), 32'(seq_rec[0][i]));
        end
        tick();
        tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
